avmm_mem_responder: RTL

AVMM_MEM_RESPONDER -- requirements
Module: avmm_mem_responder

---
 rtl/mem_pkg.sv | 16 +
 rtl/avmm_rd_pipe.sv | 31 +++
 rtl/avmm_mem_responder.sv | 70 +++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared word/lane widths, default parameters and stall-state enum for memory responders
package mem_pkg;
  localparam int WORD_W = 64;
  localparam int BE_W = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_LATENCY = 2;
  localparam int DEF_WAIT_CYCLES = 1;
  typedef enum logic [1:0] {IDLE, STALL, ACCEPT} stall_state_t;
  function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_w,
                                                 input logic [WORD_W-1:0] new_w,
                                                 input logic [BE_W-1:0] be);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < BE_W; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/avmm_rd_pipe.sv
// avmm_rd_pipe: fixed-latency valid/data shift register with synchronous clear
module avmm_rd_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              valid_in,
  input  logic [WORD_W-1:0] data_in,
  output logic              valid_out,
  output logic [WORD_W-1:0] data_out
);
  logic [LATENCY-1:0] v;
  logic [WORD_W-1:0] d [LATENCY];
  always_ff @(posedge clk) begin
    if (clr) begin
      v <= '0;
      for (int i = 0; i < LATENCY; i++) d[i] <= '0;
    end else begin
      v[0] <= valid_in;
      d[0] <= data_in;
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end
  assign valid_out = v[LATENCY-1];
  assign data_out = d[LATENCY-1];
endmodule

// File: rtl/avmm_mem_responder.sv
// avmm_mem_responder: Avalon-MM 64-bit register-array slave with stall FSM, pipelined reads and preload port
module avmm_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              mem_address,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [WORD_W-1:0]        mem_writedata,
  input  logic [BE_W-1:0]          mem_byteenable,
  output logic [WORD_W-1:0]        mem_readdata,
  output logic                     mem_readdatavalid,
  output logic                     mem_waitrequest,
  input  logic                     ld_wren,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [WORD_W-1:0]        ld_data,
  output logic [7:0]               err_cnt
);
  localparam int AW = $clog2(DEPTH);
  stall_state_t state;
  logic [2:0] cnt;
  logic [WORD_W-1:0] mem [DEPTH];
  logic cmd, acc, oor, both, illegal;
  logic [AW-1:0] idx;
  assign cmd = mem_read | mem_write;
  assign oor = mem_address >= 32'(DEPTH);
  assign both = mem_read & mem_write;
  assign illegal = oor | both;
  assign idx = mem_address[AW-1:0];
  assign mem_waitrequest = (WAIT_CYCLES != 0) && !rst && (state == STALL || (state == IDLE && cmd));
  assign acc = cmd && !mem_waitrequest && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (cmd && WAIT_CYCLES > 0) begin
          state <= (WAIT_CYCLES > 1) ? STALL : ACCEPT;
          cnt <= 3'(WAIT_CYCLES - 1);
        end
        STALL: if (!cmd) state <= IDLE;
          else if (cnt <= 3'd1) state <= ACCEPT;
          else cnt <= cnt - 3'd1;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (acc && mem_write && !illegal) mem[idx] <= be_merge(mem[idx], mem_writedata, mem_byteenable);
    if (ld_wren && !rst) mem[ld_addr] <= ld_data;
  end
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else if (acc && illegal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
  avmm_rd_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk(clk),
    .clr(rst),
    .valid_in(acc && mem_read && !mem_write),
    .data_in(oor ? '0 : mem[idx]),
    .valid_out(mem_readdatavalid),
    .data_out(mem_readdata)
  );
endmodule
